// File: rtl/mips_main_controller_if.sv
// Control bundle between the multi-cycle main controller and the datapath.
// The master side is the controller; the slave side is the datapath and funct decoder.
interface mips_main_controller_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         opcode_i;
  logic               jr_i;
  logic               zero_i;
  logic               mem_ready_i;
  logic               pc_write_o;
  logic [1:0]         pc_src_o;
  logic               ir_write_o;
  logic               mem_read_o;
  logic               mem_write_o;
  logic               iord_o;
  logic [1:0]         alu_op_o;
  logic               alu_src_o;
  logic               reg_dst_o;
  logic               mem_to_reg_o;
  logic               rtype_o;
  logic               reg_write_o;
  logic               reg_write2_o;
  logic               illegal_o;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  opcode_i, jr_i, zero_i, mem_ready_i,
    output pc_write_o, pc_src_o, ir_write_o, mem_read_o, mem_write_o, iord_o,
           alu_op_o, alu_src_o, reg_dst_o, mem_to_reg_o, rtype_o, reg_write_o,
           reg_write2_o, illegal_o, state_o
  );

  modport slave (
    output opcode_i, jr_i, zero_i, mem_ready_i,
    input  pc_write_o, pc_src_o, ir_write_o, mem_read_o, mem_write_o, iord_o,
           alu_op_o, alu_src_o, reg_dst_o, mem_to_reg_o, rtype_o, reg_write_o,
           reg_write2_o, illegal_o, state_o
  );
endinterface

// File: rtl/mips_main_controller.sv
// Multi-cycle MIPS main control FSM: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencing.
// Outputs are decoded from state; all strobes are forced low while rst_n is low.
module mips_main_controller #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int STATE_W       = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  mips_main_controller_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_R_WB     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_I_WB     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  state_t state;
  logic   is_sw;
  logic   illegal;
  logic   mem_rdy;

  assign mem_rdy = (MEM_HANDSHAKE != 0) ? bus.mem_ready_i : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      is_sw   <= 1'b0;
      illegal <= 1'b0;
    end else begin
      illegal <= 1'b0;
      case (state)
        S_FETCH:  if (mem_rdy) state <= S_DECODE;
        S_DECODE: begin
          is_sw <= (bus.opcode_i == 6'b101011);
          case (bus.opcode_i)
            6'b000000:                         state <= S_EXEC_R;
            6'b001000, 6'b001100,
            6'b001101, 6'b001010:              state <= S_EXEC_I;
            6'b100011, 6'b101011:              state <= S_MEM_ADDR;
            6'b000100:                         state <= S_BRANCH;
            6'b000010:                         state <= S_JUMP;
            default: begin
              state   <= S_FETCH;
              illegal <= 1'b1;
            end
          endcase
        end
        S_EXEC_R:   state <= bus.jr_i ? S_FETCH : S_R_WB;
        S_R_WB:     state <= S_FETCH;
        S_EXEC_I:   state <= S_I_WB;
        S_I_WB:     state <= S_FETCH;
        S_MEM_ADDR: state <= is_sw ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   if (mem_rdy) state <= S_MEM_WB;
        S_MEM_WB:   state <= S_FETCH;
        S_MEM_WR:   if (mem_rdy) state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_JUMP:     state <= S_FETCH;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Gating on rst_n keeps every strobe low from the moment reset is asserted.
  always_comb begin
    bus.pc_write_o   = 1'b0;
    bus.pc_src_o     = 2'b00;
    bus.ir_write_o   = 1'b0;
    bus.mem_read_o   = 1'b0;
    bus.mem_write_o  = 1'b0;
    bus.iord_o       = 1'b0;
    bus.alu_op_o     = 2'b00;
    bus.alu_src_o    = 1'b0;
    bus.reg_dst_o    = 1'b0;
    bus.mem_to_reg_o = 1'b0;
    bus.rtype_o      = 1'b0;
    bus.reg_write_o  = 1'b0;
    bus.reg_write2_o = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          bus.mem_read_o = 1'b1;
          bus.ir_write_o = mem_rdy;
          bus.pc_write_o = mem_rdy;
        end
        S_EXEC_R: begin
          bus.rtype_o  = 1'b1;
          bus.alu_op_o = 2'b10;
          if (bus.jr_i) begin
            bus.pc_write_o = 1'b1;
            bus.pc_src_o   = 2'b11;
          end
        end
        S_R_WB: begin
          bus.rtype_o      = 1'b1;
          bus.reg_dst_o    = 1'b1;
          bus.reg_write_o  = 1'b1;
          bus.reg_write2_o = 1'b1;
        end
        S_EXEC_I: begin
          bus.alu_src_o = 1'b1;
          bus.alu_op_o  = 2'b11;
        end
        S_I_WB: begin
          bus.alu_src_o   = 1'b1;
          bus.alu_op_o    = 2'b11;
          bus.reg_write_o = 1'b1;
        end
        S_MEM_ADDR: bus.alu_src_o = 1'b1;
        S_MEM_RD: begin
          bus.mem_read_o = 1'b1;
          bus.iord_o     = 1'b1;
        end
        S_MEM_WB: begin
          bus.mem_to_reg_o = 1'b1;
          bus.reg_write_o  = 1'b1;
        end
        S_MEM_WR: begin
          bus.mem_write_o = 1'b1;
          bus.iord_o      = 1'b1;
        end
        S_BRANCH: begin
          bus.alu_op_o   = 2'b01;
          bus.pc_src_o   = 2'b01;
          bus.pc_write_o = bus.zero_i;
        end
        S_JUMP: begin
          bus.pc_write_o = 1'b1;
          bus.pc_src_o   = 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign bus.illegal_o = illegal;
  assign bus.state_o   = STATE_W'(state);
endmodule

// File: tb/tb_mips_main_controller.sv
// Directed bench for the main controller with the memory handshake enabled.
module tb_mips_main_controller;
  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  mips_main_controller_if #(.STATE_W(4)) bus ();

  mips_main_controller #(.MEM_HANDSHAKE(1), .STATE_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [3:0] wstrobes();
    return {bus.reg_write_o, bus.reg_write2_o, bus.mem_write_o, bus.pc_write_o};
  endfunction

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    bus.opcode_i    = 6'h00;
    bus.jr_i        = 1'b0;
    bus.zero_i      = 1'b0;
    bus.mem_ready_i = 1'b1;
    #2;
    chk("reset_state", bus.state_o, 0);
    chk("reset_strobes", wstrobes(), 0);
    chk("reset_mem_read", bus.mem_read_o, 0);
    chk("reset_ir_write", bus.ir_write_o, 0);
    chk("reset_illegal", bus.illegal_o, 0);
    #10 rst_n = 1'b1;
    #1;
    chk("fetch_state", bus.state_o, 0);
    chk("fetch_mem_read", bus.mem_read_o, 1);
    chk("fetch_ir_write", bus.ir_write_o, 1);
    chk("fetch_pc_write", bus.pc_write_o, 1);
    chk("fetch_pc_src", bus.pc_src_o, 0);

    // add: 0,1,2,3,0
    step; chk("add_decode", bus.state_o, 1);
    chk("decode_strobes", wstrobes(), 0);
    step; chk("add_exec", bus.state_o, 2);
    chk("add_exec_rtype", bus.rtype_o, 1);
    chk("add_exec_aluop", bus.alu_op_o, 2);
    chk("add_exec_strobes", wstrobes(), 0);
    step; chk("add_wb", bus.state_o, 3);
    chk("add_wb_rw", bus.reg_write_o, 1);
    chk("add_wb_rw2", bus.reg_write2_o, 1);
    chk("add_wb_regdst", bus.reg_dst_o, 1);
    step; chk("add_back", bus.state_o, 0);

    // jr
    step; step; chk("jr_exec", bus.state_o, 2);
    bus.jr_i = 1'b1;
    #1;
    chk("jr_pc_write", bus.pc_write_o, 1);
    chk("jr_pc_src", bus.pc_src_o, 3);
    chk("jr_no_rw", bus.reg_write_o, 0);
    step; chk("jr_back", bus.state_o, 0);
    bus.jr_i = 1'b0;

    // FETCH holds without mem_ready
    bus.mem_ready_i = 1'b0;
    bus.opcode_i    = 6'h23;
    #1;
    chk("fetch_hold_ir", bus.ir_write_o, 0);
    chk("fetch_hold_pc", bus.pc_write_o, 0);
    chk("fetch_hold_rd", bus.mem_read_o, 1);
    step; chk("fetch_hold_state", bus.state_o, 0);
    bus.mem_ready_i = 1'b1;
    #1;
    chk("fetch_ready_ir", bus.ir_write_o, 1);

    // lw with three wait cycles in MEM_RD
    step; chk("lw_decode", bus.state_o, 1);
    step; chk("lw_addr", bus.state_o, 6);
    chk("lw_addr_alusrc", bus.alu_src_o, 1);
    chk("lw_addr_aluop", bus.alu_op_o, 0);
    bus.mem_ready_i = 1'b0;
    step; chk("lw_rd", bus.state_o, 7);
    chk("lw_rd_read", bus.mem_read_o, 1);
    chk("lw_rd_iord", bus.iord_o, 1);
    chk("lw_rd_nowrite", bus.mem_write_o, 0);
    for (int i = 0; i < 3; i++) begin
      step; chk($sformatf("lw_wait%0d", i), bus.state_o, 7);
    end
    bus.mem_ready_i = 1'b1;
    step; chk("lw_wb", bus.state_o, 8);
    chk("lw_wb_m2r", bus.mem_to_reg_o, 1);
    chk("lw_wb_rw", bus.reg_write_o, 1);
    chk("lw_wb_rw2", bus.reg_write2_o, 0);
    step; chk("lw_back", bus.state_o, 0);

    // beq not taken, then taken
    bus.opcode_i = 6'h04;
    bus.zero_i   = 1'b0;
    step; step; chk("beq0_state", bus.state_o, 10);
    chk("beq0_pc_write", bus.pc_write_o, 0);
    chk("beq0_pc_src", bus.pc_src_o, 1);
    chk("beq0_aluop", bus.alu_op_o, 1);
    step; chk("beq0_back", bus.state_o, 0);
    bus.zero_i = 1'b1;
    step; step; chk("beq1_state", bus.state_o, 10);
    chk("beq1_pc_write", bus.pc_write_o, 1);
    chk("beq1_pc_src", bus.pc_src_o, 1);
    step; chk("beq1_back", bus.state_o, 0);
    bus.zero_i = 1'b0;

    // j
    bus.opcode_i = 6'h02;
    step; step; chk("j_state", bus.state_o, 11);
    chk("j_pc_write", bus.pc_write_o, 1);
    chk("j_pc_src", bus.pc_src_o, 2);
    step; chk("j_back", bus.state_o, 0);

    // addi
    bus.opcode_i = 6'h08;
    step; step; chk("addi_exec", bus.state_o, 4);
    chk("addi_alusrc", bus.alu_src_o, 1);
    chk("addi_aluop", bus.alu_op_o, 3);
    chk("addi_exec_rw", bus.reg_write_o, 0);
    step; chk("addi_wb", bus.state_o, 5);
    chk("addi_wb_rw", bus.reg_write_o, 1);
    chk("addi_wb_regdst", bus.reg_dst_o, 0);
    step; chk("addi_back", bus.state_o, 0);

    // illegal opcode
    bus.opcode_i = 6'h3F;
    step; chk("ill_decode", bus.state_o, 1);
    chk("ill_pre", bus.illegal_o, 0);
    step; chk("ill_fetch", bus.state_o, 0);
    chk("ill_pulse", bus.illegal_o, 1);
    chk("ill_no_rw", bus.reg_write_o, 0);
    chk("ill_no_mw", bus.mem_write_o, 0);
    bus.opcode_i = 6'h2B;
    step; chk("ill_cleared", bus.illegal_o, 0);

    // sw held in MEM_WR, then reset mid-access
    step; chk("sw_addr", bus.state_o, 6);
    bus.mem_ready_i = 1'b0;
    step; chk("sw_wr", bus.state_o, 9);
    chk("sw_wr_mw", bus.mem_write_o, 1);
    chk("sw_wr_iord", bus.iord_o, 1);
    chk("sw_wr_nord", bus.mem_read_o, 0);
    step; chk("sw_hold", bus.state_o, 9);
    chk("sw_hold_mw", bus.mem_write_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mw", bus.mem_write_o, 0);
    chk("rst_state", bus.state_o, 0);
    chk("rst_strobes", wstrobes(), 0);
    #2;
    bus.mem_ready_i = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_state", bus.state_o, 0);
    chk("post_rst_ir", bus.ir_write_o, 1);
    step; chk("post_rst_decode", bus.state_o, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
